kyber_mont_convert: RTL
=======================

// Module: kyber_mont_convert
// PURPOSE
//  Streaming converter between the normal and Montgomery domains (R = 2^16, q = 3329) for Kyber coefficients.
//  TO_MONT: r = a*R mod q, computed as mont_reduce(a*1353). FROM_MONT: r = a*R^-1 mod q, computed as mont_reduce(sext(a)).
//  Three-stage valid/ready pipeline. Sits between the coefficient memory and the NTT/poly units.
//  Counts coefficients per polynomial and flags the last output coefficient of each polynomial.
// PARAMETERS
//  COEF_W    16   coefficient width (signed); only 16 is supported
//  N_COEF    256  coefficients per polynomial; drives the counter wrap
//  CANON     1    1: fold the output into [0,q); 0: output the raw Montgomery result in (-q,q)
// PORTS
//  clk_i         in   1       clock; all state updates on the rising edge
//  rstn_i        in   1       asynchronous active-low reset
//  in_valid_i    in   1       input coefficient valid
//  in_ready_o    out  1       converter can accept an input
//  in_coef_i     in   COEF_W  signed input coefficient
//  in_mode_i     in   1       0 = TO_MONT, 1 = FROM_MONT; sampled with each input beat
//  out_valid_o   out  1       output coefficient valid
//  out_ready_i   in   1       downstream accepts the output
//  out_coef_o    out  COEF_W  converted coefficient
//  out_last_o    out  1       high on output beat number N_COEF-1 of a polynomial
//  busy_o        out  1       any pipeline stage holds valid data
// BEHAVIOUR
//  Reset values: all stage valid bits 0, out_valid_o 0, out_coef_o 0, out_last_o 0, busy_o 0, counter 0.
//  in_ready_o is 1 while in reset-released idle.
//  Advance enable: adv = !out_valid_o || out_ready_i. The whole pipeline stalls when adv = 0; no stage loses data.
//  Input handshake:
//    - in_ready_o = adv, and it is purely combinational from out_ready_i and internal state.
//    - A beat is accepted when in_valid_i && in_ready_o.
//  Latency: 3 cycles from acceptance to out_valid_o when unstalled; throughput is 1 coefficient per cycle.
//  S1 (multiply):
//    - p = TO_MONT ? sext32(a)*1353 : sext32(a). Stored as 32-bit signed, with mode and valid.
//  S2 (low product):
//    - t = int16(p[15:0] * QINV), with QINV = -3327 (0xF301).
//    - Implemented with shifts/adds: t = low16(p - (p<<11) - (p<<10) - (p<<8)). Registers p, t, mode and valid.
//  S3 (reduce):
//    - d = p - sext32(t)*q, where t*q = (t<<11)+(t<<10)+(t<<8)+t; r = d[31:16].
//    - d[15:0] must be 0 for every input; an assertion covers this.
//    - If CANON=1 and r < 0, then r += q.
//    - Result r lands in the output register together with the last flag.
//  Output hold: out_valid_o, out_coef_o and out_last_o stay stable while out_valid_o && !out_ready_i.
//  Counter:
//    - 8-bit counter of output handshakes (out_valid_o && out_ready_i).
//    - out_last_o = (cnt == N_COEF-1) && out_valid_o. It is computed from the registered counter.
//    - The counter wraps to 0 on the handshake of the last beat.
//  Mode mixing: mode travels with each beat, so consecutive beats with different modes are legal.
//  Reset mid-operation: in-flight data is discarded, all valid bits clear and the counter returns to 0.
//  Edge inputs: -32768 and 32767 are valid inputs. No overflow is possible: |a*1353| < 2^26 and |t*q| < 2^27.
// STRUCTURE
//  Shared package kyber_pkg:
//    - KYBER_Q = 3329, KYBER_QINV = -3327, MONT_R2 = 1353, MONT_RINV = 169.
//    - typedef coef_t (logic signed [15:0]).
//    - typedef mont_mode_e {TO_MONT, FROM_MONT}.
//  One natural sub-module: kyber_mont_reduce_comb, the combinational S2/S3 shift-add math.
//  It can be instantiated twice, split at the t register.
//  The top level holds the stage registers, the handshake, the counter and the canonical fold.
// TESTING
//  1. TO_MONT a=1, CANON=0 -> out -1044 after 3 cycles; with CANON=1 -> 2285.
//  2. FROM_MONT a=2285 -> 1; FROM_MONT a=-1 -> -169 (CANON=0) or 3160 (CANON=1); a=0 in either mode -> 0.
//  3. Burst of 256 TO_MONT beats with out_ready_i=1 -> 256 outputs, one per cycle.
//     out_last_o high only on beat 255, then the counter restarts at 0 for the next polynomial.
//  4. Random out_ready_i backpressure (~50%) over 1000 beats of random a and mode:
//     every output equals the C reference fqmul/montgomery_reduce; no drops or duplicates; outputs stable while stalled.
//  5. Round trip: FROM_MONT(TO_MONT(a)) mod q == a mod q for all 65536 inputs, including -32768 and 32767.
//  6. Assert rstn_i low with 3 beats in flight and the counter at 100 -> all valids 0 immediately.
//     After release: busy_o=0, counter 0, and the next polynomial's out_last_o arrives on beat 255.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and conversion-mode encoding.
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_QINV = -3327;  // q^-1 mod 2^16, signed form (0xF301)
  localparam int MONT_R2    = 1353;   // R^2 mod q, so mont_reduce(a*R2) = a*R mod q
  localparam int MONT_RINV  = 169;    // R^-1 mod q

  typedef logic signed [15:0] coef_t;

  typedef enum logic {
    TO_MONT   = 1'b0,
    FROM_MONT = 1'b1
  } mont_mode_e;

  // Sign-extend a coefficient to the 32-bit product width.
  function automatic logic signed [31:0] sext32(input coef_t a);
    return {{16{a[15]}}, a};
  endfunction

endpackage

// File: rtl/kyber_mont_reduce_comb.sv
// Combinational Montgomery-reduction math, split at the t register:
//   t_next = low16(p * QINV) from the S1 product (shift/add form),
//   d      = p - sext32(t) * q from the registered S2 product and t.
// The low 16 bits of d are zero for every legal p; the caller keeps d[31:16].
module kyber_mont_reduce_comb
  import kyber_pkg::*;
(
  input  logic [15:0] p_lo,    // low half of the S1 product
  input  logic [31:0] p,       // S2 product
  input  coef_t       t,       // registered S2 low product
  output coef_t       t_next,
  output logic [31:0] d
);

  logic [31:0] t_ext;
  logic [31:0] tq;

  // QINV = -3327 = 1 - 2^11 - 2^10 - 2^8; only the low 16 bits matter.
  assign t_next = p_lo - (p_lo << 11) - (p_lo << 10) - (p_lo << 8);

  // q = 3329 = 2^11 + 2^10 + 2^8 + 1.
  assign t_ext = sext32(t);
  assign tq    = (t_ext << 11) + (t_ext << 10) + (t_ext << 8) + t_ext;
  assign d     = p - tq;

endmodule

// File: rtl/kyber_mont_convert.sv
// Streaming normal <-> Montgomery domain converter for Kyber coefficients.
// Three register stages: S1 product, S2 product + low product t, S3 output.
// Counts output handshakes per polynomial and flags the last coefficient.
module kyber_mont_convert
  import kyber_pkg::*;
#(
  parameter int COEF_W = 16,   // only 16 is supported
  parameter int N_COEF = 256,
  parameter int CANON  = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [COEF_W-1:0] in_coef_i,
  input  logic              in_mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [COEF_W-1:0] out_coef_o,
  output logic              out_last_o,
  output logic              busy_o
);

  // Handshake: a beat moves on an edge where valid && ready. The whole pipe
  // advances together when the output register is empty or being drained
  // (adv); otherwise every stage holds, so in_ready_o = adv and the output
  // beat stays stable until the downstream accepts it.

  localparam logic signed [31:0] R2_W = MONT_R2;

  logic               adv;
  logic signed [31:0] a_ext;
  logic        [31:0] p_next;

  logic               s1_valid;
  logic        [31:0] s1_p;
  logic               s2_valid;
  logic        [31:0] s2_p;
  coef_t              s2_t;

  coef_t              t_next;
  logic        [31:0] d;
  coef_t              r_raw;
  coef_t              r_fold;

  logic        [7:0]  cnt;
  logic               last_beat;

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;
  assign busy_o     = s1_valid || s2_valid || out_valid_o;

  // Mode is consumed here: it selects the S1 product, so later stages need
  // nothing but p and t, and neighbouring beats may use different modes.
  assign a_ext  = sext32(coef_t'(in_coef_i));
  assign p_next = (mont_mode_e'(in_mode_i) == FROM_MONT) ? a_ext : a_ext * R2_W;

  kyber_mont_reduce_comb u_reduce (
    .p_lo   (s1_p[15:0]),
    .p      (s2_p),
    .t      (s2_t),
    .t_next (t_next),
    .d      (d)
  );

  // Raw result lies in (-q, q); optionally fold negatives into [0, q).
  assign r_raw  = d[31:16];
  assign r_fold = (CANON != 0 && r_raw[15]) ? r_raw + coef_t'(KYBER_Q) : r_raw;

  // Stage registers; everything moves together on adv.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_valid    <= 1'b0;
      s1_p        <= '0;
      s2_valid    <= 1'b0;
      s2_p        <= '0;
      s2_t        <= '0;
      out_valid_o <= 1'b0;
      out_coef_o  <= '0;
    end else if (adv) begin
      s1_valid    <= in_valid_i;
      s1_p        <= p_next;
      s2_valid    <= s1_valid;
      s2_p        <= s1_p;
      s2_t        <= t_next;
      out_valid_o <= s2_valid;
      if (s2_valid) begin
        out_coef_o <= r_fold;
      end
    end
  end

  // Output-handshake counter; wraps after the last beat of a polynomial.
  assign last_beat  = (cnt == 8'(N_COEF - 1));
  assign out_last_o = last_beat && out_valid_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (out_valid_o && out_ready_i) begin
      cnt <= last_beat ? 8'd0 : cnt + 8'd1;
    end
  end

  // Montgomery invariant: the subtraction clears the low half exactly.
  assert property (@(posedge clk_i) disable iff (!rstn_i)
                   s2_valid |-> (d[15:0] == 16'h0000));

endmodule
